// File: rtl/rgb_fade_source.sv
// rgb_fade_source: colour source feeding rgb_controller.
// Raw RGB565 switches are synchronised and debounced, then expanded to three
// 8-bit targets. Each output channel ramps toward its target by one LSB per
// step tick, or jumps straight to it when snap is asserted.
module rgb_fade_source #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int STEP_CYCLES     = 390_625
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] SW,
  input  logic        snap,
  output logic [7:0]  r_out,
  output logic [7:0]  g_out,
  output logic [7:0]  b_out,
  output logic        busy
);

  // Counter widths, kept at least one bit for the degenerate parameter values.
  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  // The debounce counter saturates at DB_MAX; a target load happens on the
  // edge where sw_s is still unchanged with the counter already saturated,
  // which makes DEBOUNCE_CYCLES consecutive equal comparisons.
  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(STEP_CYCLES - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FADE = 1'b1
  } state_t;

  // Move one LSB toward the target; never passes it, so no wrap is possible.
  function automatic logic [7:0] f_step(input logic [7:0] cur, input logic [7:0] tgt);
    logic [7:0] res;
    res = cur;
    if (cur < tgt) begin
      res = cur + 8'd1;
    end else if (cur > tgt) begin
      res = cur - 8'd1;
    end
    return res;
  endfunction

  // Synchroniser and debounce state
  logic [15:0]       r_sw_meta;
  logic [15:0]       r_sw_s;
  logic [15:0]       r_sw_prev;
  logic [DB_W-1:0]   r_db_cnt;

  // Targets and channel levels
  logic [7:0]        r_r_t;
  logic [7:0]        r_g_t;
  logic [7:0]        r_b_t;
  logic [7:0]        r_r_out;
  logic [7:0]        r_g_out;
  logic [7:0]        r_b_out;

  // Fade control
  state_t            r_state;
  logic [STEP_W-1:0] r_step_cnt;

  // Combinational next-state values
  logic              w_sw_same;
  logic              w_db_load;
  logic [DB_W-1:0]   w_db_cnt_next;
  logic [7:0]        w_r_t_next;
  logic [7:0]        w_g_t_next;
  logic [7:0]        w_b_t_next;
  logic              w_tick;
  logic              w_out_ne_t;
  state_t            w_state_next;
  logic [STEP_W-1:0] w_step_cnt_next;
  logic [7:0]        w_r_next;
  logic [7:0]        w_g_next;
  logic [7:0]        w_b_next;

  // Two-flop synchroniser plus one-cycle history used for change detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sw_meta <= '0;
      r_sw_s    <= '0;
      r_sw_prev <= '0;
    end else begin
      r_sw_meta <= SW;
      r_sw_s    <= r_sw_meta;
      r_sw_prev <= r_sw_s;
    end
  end

  assign w_sw_same = (r_sw_s == r_sw_prev);
  assign w_db_load = w_sw_same && (r_db_cnt == DB_MAX);

  // Stable-time counter: cleared on any change, otherwise counts up and holds.
  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_db_cnt_next = r_db_cnt;
    if (!w_sw_same) begin
      w_db_cnt_next = '0;
    end else if (r_db_cnt != DB_MAX) begin
      w_db_cnt_next = r_db_cnt + DB_W'(1);
    end
  end

  // Target expansion with zero-padded LSBs; targets hold unless a load fires.
  always_comb begin
    w_r_t_next = r_r_t;
    w_g_t_next = r_g_t;
    w_b_t_next = r_b_t;
    if (w_db_load) begin
      w_r_t_next = {r_sw_s[15:11], 3'b000};
      w_g_t_next = {r_sw_s[10:5],  2'b00};
      w_b_t_next = {r_sw_s[4:0],   3'b000};
    end
  end

  // Debounce counter and target registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_db_cnt <= '0;
      r_r_t    <= '0;
      r_g_t    <= '0;
      r_b_t    <= '0;
    end else begin
      r_db_cnt <= w_db_cnt_next;
      r_r_t    <= w_r_t_next;
      r_g_t    <= w_g_t_next;
      r_b_t    <= w_b_t_next;
    end
  end

  assign w_tick     = (r_step_cnt == STEP_MAX);
  assign w_out_ne_t = ({r_r_out, r_g_out, r_b_out} != {r_r_t, r_g_t, r_b_t});

  // Fade FSM next-state, step counter and channel updates.
  // Steps aim at the registered targets, so a target accepted mid-fade changes
  // direction on the following tick without restarting the step counter. The
  // exit test uses the post-edge values so IDLE (and busy low) coincides with
  // the last channel arriving.
  always_comb begin
    w_state_next    = r_state;
    w_step_cnt_next = r_step_cnt;
    w_r_next        = r_r_out;
    w_g_next        = r_g_out;
    w_b_next        = r_b_out;
    if (snap) begin
      // Jump takes the target being loaded on this same edge, if any.
      w_state_next    = ST_IDLE;
      w_step_cnt_next = '0;
      w_r_next        = w_r_t_next;
      w_g_next        = w_g_t_next;
      w_b_next        = w_b_t_next;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_out_ne_t) begin
            w_state_next    = ST_FADE;
            w_step_cnt_next = '0;
          end
        end
        ST_FADE: begin
          if (w_tick) begin
            w_step_cnt_next = '0;
            w_r_next        = f_step(r_r_out, r_r_t);
            w_g_next        = f_step(r_g_out, r_g_t);
            w_b_next        = f_step(r_b_out, r_b_t);
          end else begin
            w_step_cnt_next = r_step_cnt + STEP_W'(1);
          end
          if ({w_r_next, w_g_next, w_b_next} == {w_r_t_next, w_g_t_next, w_b_t_next}) begin
            w_state_next    = ST_IDLE;
            w_step_cnt_next = '0;
          end
        end
        default: begin
          w_state_next    = ST_IDLE;
          w_step_cnt_next = '0;
        end
      endcase
    end
  end

  // FSM state, step counter and output level registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= ST_IDLE;
      r_step_cnt <= '0;
      r_r_out    <= '0;
      r_g_out    <= '0;
      r_b_out    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_step_cnt <= w_step_cnt_next;
      r_r_out    <= w_r_next;
      r_g_out    <= w_g_next;
      r_b_out    <= w_b_next;
    end
  end

  assign r_out = r_r_out;
  assign g_out = r_g_out;
  assign b_out = r_b_out;

  // Derived only from registers, so SW activity cannot glitch it.
  assign busy = (r_state == ST_FADE) || w_out_ne_t;

endmodule
